// File: rtl/rh11_dma_xfer.sv
// RH11 data-transfer sequencer: moves one 36-bit word per iteration between the
// drive data path and KS10 memory, stepping RHWC/BA until the word count wraps to zero.
module rh11_dma_xfer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        rhGO,
    input  logic        rhREAD,
    input  logic [15:0] rhWC,
    input  logic [17:0] rhBA,
    input  logic        drvRDY,
    input  logic [35:0] drvDATAI,
    output logic [35:0] drvDATAO,
    output logic        drvSTB,
    output logic        dmaREQ,
    input  logic        dmaACK,
    output logic        dmaWRITE,
    output logic [17:0] dmaADDR,
    input  logic [35:0] dmaDATAI,
    output logic [35:0] dmaDATAO,
    output logic        rhINCWC,
    output logic        rhINCBA,
    output logic        rhBUSY,
    output logic        rhDONE,
    output logic        rhNXM
);

    typedef enum logic [2:0] {
        IDLE,
        DRVWAIT,
        BUSREQ,
        DRVPUT,
        INC,
        DONE
    } state_t;

    // The last un-acked request cycle is the one whose count is TIMEOUT-1,
    // so dmaREQ stays up for exactly TIMEOUT cycles before NXM is flagged.
    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t      state_q;
    logic        dir_q;
    logic [35:0] buf_q;
    logic [5:0]  cnt_q;
    logic        stb_q;
    logic        nxm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            nxm_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            cnt_q <= '0;
            if (devRESET || rhCLR) begin
                state_q <= IDLE;
                nxm_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rhGO) begin
                            nxm_q   <= 1'b0;
                            dir_q   <= rhREAD;
                            state_q <= rhREAD ? DRVWAIT : BUSREQ;
                        end
                    end
                    DRVWAIT: begin
                        if (drvRDY) begin
                            buf_q   <= drvDATAI;
                            stb_q   <= 1'b1;
                            state_q <= BUSREQ;
                        end
                    end
                    BUSREQ: begin
                        // An ack arriving on the final count still completes the word.
                        if (dmaACK) begin
                            if (!dir_q) begin
                                buf_q <= dmaDATAI;
                            end
                            state_q <= dir_q ? INC : DRVPUT;
                        end else if (cnt_q == CNT_LAST) begin
                            nxm_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    DRVPUT: begin
                        if (drvRDY) begin
                            stb_q   <= 1'b1;
                            state_q <= INC;
                        end
                    end
                    INC: begin
                        if (rhWC == 16'hFFFF) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= dir_q ? DRVWAIT : BUSREQ;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rhBUSY   = (state_q != IDLE);
    assign dmaREQ   = (state_q == BUSREQ);
    assign dmaWRITE = dmaREQ & dir_q;
    assign dmaADDR  = rhBUSY ? rhBA : '0;
    assign dmaDATAO = buf_q;
    assign drvDATAO = buf_q;
    assign drvSTB   = stb_q;
    assign rhINCWC  = (state_q == INC);
    assign rhINCBA  = (state_q == INC);
    assign rhDONE   = (state_q == DONE);
    assign rhNXM    = nxm_q;

endmodule

// File: tb/tb_rh11_dma_xfer.sv
// Bench for rh11_dma_xfer: directed and randomized transfers against a
// transaction-level model of words moved, strobes, increments and completion.
module tb_rh11_dma_xfer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        devRESET = 1'b0;
    logic        rhCLR = 1'b0;
    logic        rhGO = 1'b0;
    logic        rhREAD = 1'b0;
    logic [15:0] rhWC = 16'h0;
    logic [17:0] rhBA = 18'h2AAAA;
    logic        drvRDY = 1'b0;
    logic [35:0] drvDATAI = '0;
    logic        dmaACK = 1'b0;
    logic [35:0] dmaDATAI = '0;
    logic [35:0] drvDATAO, dmaDATAO;
    logic [17:0] dmaADDR;
    logic        drvSTB, dmaREQ, dmaWRITE, rhINCWC, rhINCBA, rhBUSY, rhDONE, rhNXM;

    rh11_dma_xfer #(.TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR), .rhGO(rhGO),
        .rhREAD(rhREAD), .rhWC(rhWC), .rhBA(rhBA), .drvRDY(drvRDY),
        .drvDATAI(drvDATAI), .drvDATAO(drvDATAO), .drvSTB(drvSTB), .dmaREQ(dmaREQ),
        .dmaACK(dmaACK), .dmaWRITE(dmaWRITE), .dmaADDR(dmaADDR), .dmaDATAI(dmaDATAI),
        .dmaDATAO(dmaDATAO), .rhINCWC(rhINCWC), .rhINCBA(rhINCBA), .rhBUSY(rhBUSY),
        .rhDONE(rhDONE), .rhNXM(rhNXM)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total = 0;
    int fails = 0;

    int cyc = 0;
    int n_inc, n_incba, n_done, n_stb, n_req_cyc, n_req_starts, n_acks;
    int req_age, inc_at_done, bad_wr, bad_addr;
    int first_ack_cyc, first_stb_cyc, abort_cyc;
    int ack_delay = 0;
    int rdy_pct = 100;
    int rdy_hold = 0;
    int hold_next = 0;
    int abort_at = 0;
    int drv_idx, mem_idx, exp_n;
    logic prev_req;
    logic inc_pend = 1'b0;
    logic cur_dir;
    logic [17:0] ba0;
    logic fixed_w0_en = 1'b0;
    logic [35:0] fixed_w0 = '0;
    logic [35:0] drv_words[$];
    logic [35:0] mem_words[$];
    logic [35:0] memw_q[$];
    logic [35:0] drvput_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rword();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    // One clock: let the edge pass, then observe outputs and set up the next inputs.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rhGO = 1'b0;
        rhCLR = 1'b0;
        devRESET = 1'b0;
        if (inc_pend) begin
            rhWC = rhWC + 16'd1;
            rhBA = rhBA + 18'd1;
            inc_pend = 1'b0;
        end
        #1;
        if (dmaREQ) begin
            n_req_cyc++;
            if (!prev_req) begin
                n_req_starts++;
                req_age = 0;
            end else begin
                req_age++;
            end
        end
        prev_req = dmaREQ;
        if (drvSTB) begin
            n_stb++;
            if (first_stb_cyc < 0) first_stb_cyc = cyc;
            if (cur_dir) drv_idx++;
            else drvput_q.push_back(drvDATAO);
        end
        if (rhINCWC) begin
            n_inc++;
            inc_pend = 1'b1;
        end
        if (rhINCBA) n_incba++;
        if (rhDONE) begin
            n_done++;
            inc_at_done = n_inc;
        end
        drvDATAI = (drv_idx < drv_words.size()) ? drv_words[drv_idx] : '0;
        dmaDATAI = (mem_idx < mem_words.size()) ? mem_words[mem_idx] : '0;
        dmaACK = 1'b0;
        if (dmaREQ) begin
            if (abort_at != 0 && n_req_starts == abort_at && req_age == 0) begin
                rhCLR = 1'b1;
                abort_cyc = cyc;
            end else if (ack_delay >= 0 && req_age >= ack_delay) begin
                dmaACK = 1'b1;
                if (dmaWRITE !== cur_dir) bad_wr++;
                if (dmaADDR !== 18'(ba0 + 18'(n_acks))) bad_addr++;
                n_acks++;
                if (dmaWRITE) memw_q.push_back(dmaDATAO);
                else mem_idx++;
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
                if (!cur_dir && hold_next > 0) begin
                    rdy_hold = hold_next;
                    hold_next = 0;
                end
            end
        end
        if (rdy_hold > 0) begin
            drvRDY = 1'b0;
            rdy_hold--;
        end else begin
            drvRDY = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    endtask

    task automatic start(input logic dir, input logic [15:0] wc, input logic [17:0] ba);
        exp_n = (wc == 16'h0) ? 65536 : 65536 - int'(wc);
        ba0 = ba;
        cur_dir = dir;
        drv_words.delete();
        mem_words.delete();
        memw_q.delete();
        drvput_q.delete();
        for (int i = 0; i < exp_n; i++) begin
            drv_words.push_back(rword());
            mem_words.push_back(rword());
        end
        if (fixed_w0_en) mem_words[0] = fixed_w0;
        n_inc = 0; n_incba = 0; n_done = 0; n_stb = 0; n_req_cyc = 0;
        n_req_starts = 0; n_acks = 0; req_age = 0; inc_at_done = -1;
        bad_wr = 0; bad_addr = 0; first_ack_cyc = -1; first_stb_cyc = -1;
        abort_cyc = -100; drv_idx = 0; mem_idx = 0; prev_req = 1'b0;
        drvDATAI = drv_words[0];
        dmaDATAI = mem_words[0];
        rhREAD = dir;
        rhWC = wc;
        rhBA = ba;
        rhGO = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (rhBUSY && k < budget) begin
            tick();
            k++;
        end
        check_int({tag, "_idle"}, int'(rhBUSY), 0);
    endtask

    task automatic check_xfer(input string tag);
        check_int({tag, "_incwc"}, n_inc, exp_n);
        check_int({tag, "_incba"}, n_incba, exp_n);
        check_int({tag, "_stb"}, n_stb, exp_n);
        check_int({tag, "_done"}, n_done, 1);
        check_int({tag, "_done_after_last_inc"}, inc_at_done, exp_n);
        check_int({tag, "_nxm"}, int'(rhNXM), 0);
        check_int({tag, "_dmawrite_dir"}, bad_wr, 0);
        check_int({tag, "_addr"}, bad_addr, 0);
        check_int({tag, "_wc_final"}, int'(rhWC), 0);
        check_int({tag, "_ba_final"}, int'(rhBA), int'(18'(ba0 + 18'(exp_n))));
        if (cur_dir) begin
            check_int({tag, "_nwords"}, memw_q.size(), exp_n);
            for (int i = 0; i < exp_n && i < memw_q.size(); i++)
                check_word({tag, "_memdata"}, 64'(memw_q[i]), 64'(drv_words[i]));
        end else begin
            check_int({tag, "_nwords"}, drvput_q.size(), exp_n);
            for (int i = 0; i < exp_n && i < drvput_q.size(); i++)
                check_word({tag, "_drvdata"}, 64'(drvput_q[i]), 64'(mem_words[i]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, "_ctl"}, int'({rhBUSY, dmaREQ, drvSTB, rhINCWC, rhINCBA,
                                      rhDONE, rhNXM, dmaWRITE}), 0);
        check_word({tag, "_drvdatao"}, 64'(drvDATAO), 64'h0);
        check_word({tag, "_dmadatao"}, 64'(dmaDATAO), 64'h0);
        check_word({tag, "_dmaaddr"}, 64'(dmaADDR), 64'h0);
    endtask

    initial begin
        logic dir;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Abort and start in the same cycle: abort wins.
        rhGO = 1'b1;
        rhREAD = 1'b1;
        devRESET = 1'b1;
        tick();
        check_int("abort_beats_go", int'(rhBUSY), 0);

        // Read of three words, ack two cycles into each request, BA wraps.
        rdy_pct = 100;
        ack_delay = 2;
        start(1'b1, 16'hFFFD, 18'h3FFFE);
        wait_idle("read3", 500);
        check_xfer("read3");

        // Write of one fixed word.
        ack_delay = 0;
        fixed_w0_en = 1'b1;
        fixed_w0 = 36'o123456701234;
        start(1'b0, 16'hFFFF, 18'h00100);
        fixed_w0_en = 1'b0;
        wait_idle("write1", 500);
        check_xfer("write1");

        // Timeout: no ack ever.
        ack_delay = -1;
        start(1'b0, 16'hFFFF, 18'h01000);
        wait_idle("tmo", 500);
        check_int("tmo_req_cycles", n_req_cyc, 63);
        check_int("tmo_nxm", int'(rhNXM), 1);
        check_int("tmo_done", n_done, 1);
        check_int("tmo_inc", n_inc, 0);
        check_int("tmo_stb", n_stb, 0);
        repeat (5) tick();
        check_int("tmo_nxm_sticky", int'(rhNXM), 1);
        ack_delay = 1;
        start(1'b0, 16'hFFFF, 18'h01000);
        check_int("tmo_nxm_cleared_by_go", int'(rhNXM), 0);
        wait_idle("after_tmo", 500);
        check_xfer("after_tmo");

        // Controller clear in the request phase of word 2 of 4.
        ack_delay = 1;
        abort_at = 2;
        start(1'b1, 16'hFFFC, 18'h02000);
        wait_idle("abort", 500);
        abort_at = 0;
        check_int("abort_latency", cyc - abort_cyc, 1);
        check_int("abort_req_low", int'(dmaREQ), 0);
        repeat (4) tick();
        check_int("abort_done", n_done, 0);
        check_int("abort_inc", n_inc, 1);
        check_int("abort_stb", n_stb, 2);
        check_int("abort_nxm", int'(rhNXM), 0);

        // Backpressure in DRVPUT plus a start pulse while busy.
        ack_delay = 0;
        rdy_pct = 100;
        hold_next = 11;
        start(1'b0, 16'hFFFE, 18'h03000);
        repeat (3) tick();
        rhREAD = 1'b1;
        rhGO = 1'b1;
        tick();
        wait_idle("bp", 500);
        check_int("bp_stb_delay", first_stb_cyc - first_ack_cyc, 12);
        check_xfer("bp");

        // Asynchronous reset while in INC.
        ack_delay = 0;
        start(1'b1, 16'hFFFD, 18'h04000);
        for (int k = 0; k < 200 && n_inc == 0; k++) tick();
        check_int("arst_in_inc", int'(rhINCWC), 1);
        rst = 1'b0;
        #1;
        check_all_zero("arst");
        inc_pend = 1'b0;
        tick();
        rst = 1'b1;
        check_int("arst_idle", int'(rhBUSY), 0);
        ack_delay = 3;
        start(1'b1, 16'hFFFE, 18'h05000);
        wait_idle("arst_fresh", 500);
        check_xfer("arst_fresh");

        // Randomized transfers.
        for (int t = 0; t < 6; t++) begin
            dir = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 5));
            ack_delay = int'($urandom_range(0, 4));
            rdy_pct = int'($urandom_range(30, 100));
            start(dir, 16'(65536 - n), 18'($urandom()));
            wait_idle("rand", 3000);
            check_xfer("rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
